// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS pipeline.
// Registers the operands from the register file together with the decoded
// fields for EX. It also detects load-use hazards, which stall IF/ID, and
// inserts bubbles on a stall, on a flush, or when ID holds no instruction.
// Optional feature macro: ID_WB_BYPASS_EN. When it is defined, a write from
// WB in the same cycle is forwarded into the captured operands.
//
// Flow control: id_valid qualifies every id_* field. The only backpressure
// is stall_out. While stall_out=1, ID must hold its instruction and present
// it again on the next cycle, and this stage loads a bubble. EX never
// applies backpressure, so ex_valid marks a real instruction for exactly one
// cycle.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic [DW-1:0]    id_imm,
  input  logic [CW-1:0]    id_ctrl,
  input  logic             id_mem_read,
  input  logic             id_reg_write,
  input  logic [DW-1:0]    rdata_A,
  input  logic [DW-1:0]    rdata_B,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  input  logic             flush,
  output logic             stall_out,
  output logic             ex_valid,
  output logic [DW-1:0]    ex_pc,
  output logic [DW-1:0]    ex_a,
  output logic [DW-1:0]    ex_b,
  output logic [DW-1:0]    ex_imm,
  output logic [AW-1:0]    ex_rs,
  output logic [AW-1:0]    ex_rt,
  output logic [AW-1:0]    ex_rd,
  output logic [CW-1:0]    ex_ctrl,
  output logic             ex_mem_read,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          hazard;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // Load-use check: the load now in EX writes a register that ID reads.
  // A flush kills the ID instruction, so a flush suppresses the stall.
  always_comb begin
    hazard = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
    stall_out = hazard && !flush;
  end

`ifndef ID_WB_BYPASS_EN
  // Without bypass the WB port is not needed. Reducing it here keeps it
  // visibly consumed.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  // Operand select: r0 always reads 0. With bypass enabled, a WB write in
  // the same cycle takes priority over the register file read data.
  always_comb begin
    op_a = rdata_A;
    op_b = rdata_B;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && (wb_addr != '0) && (wb_addr == id_rs)) op_a = wb_data;
    if (wb_we && (wb_addr != '0) && (wb_addr == id_rt)) op_b = wb_data;
`endif
    if (id_rs == '0) op_a = '0;
    if (id_rt == '0) op_b = '0;
  end

  // Pipeline register. Priority is flush, then stall, then empty ID, then
  // capture. Every bubble clears all fields so that EX state stays
  // deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush || stall_out || !id_valid) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_a         <= op_a;
      ex_b         <= op_b;
      ex_imm       <= id_imm;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_ctrl;
      ex_mem_read  <= id_mem_read;
      ex_reg_write <= id_reg_write;
    end
  end

  // Saturating count of load-use bubbles only. Flush bubbles and empty-ID
  // bubbles are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_out && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: bench for id_ex_stage. It runs directed scenarios and
// random traffic. Expected values come from a record-level model of the EX
// slot. When ID_WB_BYPASS_EN is defined, the model applies the bypass rule.
module tb_id_ex_stage;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int CNT_W = 4;
  localparam int REC_W = 1 + 4*DW + 3*AW + CW + 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic          valid;
    logic [DW-1:0] pc;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
    logic          mr, rw;
    logic [DW-1:0] ra, rb;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
  } stim_t;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_mem_read, id_reg_write, wb_we, flush;
  logic [DW-1:0] id_pc, id_imm, rdata_A, rdata_B, wb_data;
  logic [AW-1:0] id_rs, id_rt, id_rd, wb_addr;
  logic [CW-1:0] id_ctrl;
  logic stall_out, ex_valid, ex_mem_read, ex_reg_write;
  logic [DW-1:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .rdata_A(rdata_A), .rdata_B(rdata_B),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [REC_W-1:0] exp_q[$];

  // Model of the EX slot: only what hazard detection needs, plus the counter.
  logic          m_valid;
  logic          m_mr;
  logic [AW-1:0] m_rt;
  int            m_cnt;
  logic          last_stall;

  task automatic check_eq(input string tag, input logic [191:0] obs,
                          input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] dut_rec();
    return {ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd,
            ex_ctrl, ex_mem_read, ex_reg_write};
  endfunction

  // Value the operand should carry for register addr given read data rd.
  function automatic logic [DW-1:0] op_val(input logic [AW-1:0] addr,
                                           input logic [DW-1:0] rd,
                                           input stim_t s);
    if (addr == 0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (s.wb_we && s.wb_addr == addr) return s.wb_data;
`endif
    return rd;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.valid = 0; s.pc = '0; s.rs = '0; s.rt = '0; s.rd = '0; s.imm = '0;
    s.ctrl = '0; s.mr = 0; s.rw = 0; s.ra = '0; s.rb = '0; s.wb_we = 0;
    s.wb_addr = '0; s.wb_data = '0; s.flush = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid   = ($urandom_range(0, 99) < 85);
    s.pc      = $urandom;
    s.rs      = AW'($urandom_range(0, 7));
    s.rt      = AW'($urandom_range(0, 7));
    s.rd      = AW'($urandom_range(0, 31));
    s.imm     = $urandom;
    s.ctrl    = CW'($urandom);
    s.mr      = ($urandom_range(0, 99) < 35);
    s.rw      = 1'($urandom);
    s.ra      = $urandom;
    s.rb      = $urandom;
    s.wb_we   = 1'($urandom);
    s.wb_addr = AW'($urandom_range(0, 7));
    s.wb_data = $urandom;
    s.flush   = ($urandom_range(0, 99) < 10);
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input stim_t s);
    id_valid = s.valid; id_pc = s.pc; id_rs = s.rs; id_rt = s.rt;
    id_rd = s.rd; id_imm = s.imm; id_ctrl = s.ctrl; id_mem_read = s.mr;
    id_reg_write = s.rw; rdata_A = s.ra; rdata_B = s.rb; wb_we = s.wb_we;
    wb_addr = s.wb_addr; wb_data = s.wb_data; flush = s.flush;
  endtask

  task automatic model_clear();
    m_valid = 0; m_mr = 0; m_rt = '0; m_cnt = 0; last_stall = 0;
  endtask

  // One pipeline cycle: drive at the negedge, check stall_out, predict, then
  // check the registered record after the rising edge.
  task automatic step(input stim_t s);
    logic hz, stl, cap;
    logic [REC_W-1:0] e;
    @(negedge clk);
    apply(s);
    #1;
    hz  = m_valid && m_mr && s.valid && (m_rt != 0) &&
          (m_rt == s.rs || m_rt == s.rt);
    stl = hz && !s.flush;
    check_eq("stall_out", {191'd0, stall_out}, {191'd0, stl});
    cap = s.valid && !s.flush && !stl;
    if (cap) e = {1'b1, s.pc, op_val(s.rs, s.ra, s), op_val(s.rt, s.rb, s),
                  s.imm, s.rs, s.rt, s.rd, s.ctrl, s.mr, s.rw};
    else     e = '0;
    exp_q.push_back(e);
    if (stl && m_cnt < CNT_MAX) m_cnt++;
    m_valid = cap; m_mr = cap && s.mr; m_rt = cap ? s.rt : '0;
    last_stall = stl;
    @(posedge clk);
    #1;
    check_eq("ex_rec", dut_rec(), exp_q.pop_front());
    check_eq("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Async reset with inputs toggling; checked before any clock edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 0;
    #1;
    check_eq("rst_async_rec", dut_rec(), '0);
    for (int i = 0; i < cycles; i++) begin
      apply(rand_stim());
      @(posedge clk); #1;
      check_eq("rst_rec", dut_rec(), '0);
      check_eq("rst_cnt", stall_cnt, 0);
      check_eq("rst_stall", stall_out, 0);
      @(negedge clk);
    end
    model_clear();
    apply(idle_stim());
    rst = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stim_t s, ld, use_s;
    rst = 1;
    apply(idle_stim());
    model_clear();
    do_reset(4);

    // Basic capture
    s = idle_stim();
    s.valid = 1; s.pc = 32'h40; s.ra = 5; s.rb = 6; s.rs = 5; s.rt = 6;
    step(s);
    check_eq("t1_valid", ex_valid, 1);
    check_eq("t1_pc", ex_pc, 32'h40);
    check_eq("t1_a", ex_a, 5);
    check_eq("t1_b", ex_b, 6);

    // Zero register
    s = idle_stim();
    s.valid = 1; s.rs = 0; s.rt = 3; s.ra = 32'hDEADBEEF; s.rb = 9;
    step(s);
    check_eq("t2_a_zero", ex_a, 0);

    // Load-use: one bubble, then the held instruction is captured
    ld = idle_stim();
    ld.valid = 1; ld.mr = 1; ld.rw = 1; ld.rt = 7; ld.rs = 2; ld.pc = 32'h100;
    step(ld);
    use_s = idle_stim();
    use_s.valid = 1; use_s.rs = 7; use_s.rt = 1; use_s.pc = 32'h104;
    use_s.ra = 32'h1234;
    step(use_s);
    check_eq("t3_bubble", ex_valid, 0);
    check_eq("t3_cnt", stall_cnt, 1);
    step(use_s);
    check_eq("t3_capture", ex_valid, 1);
    check_eq("t3_pc", ex_pc, 32'h104);

    // Flush beats hazard; a flush of a plain instruction is also a bubble
    step(ld);
    s = use_s; s.flush = 1;
    step(s);
    check_eq("t4_cnt_hold", stall_cnt, 1);
    s = idle_stim();
    s.valid = 1; s.rs = 1; s.rt = 2; s.flush = 1; s.pc = 32'h200;
    step(s);
    check_eq("t4_flush_bubble", ex_valid, 0);

    // WB bypass
    s = idle_stim();
    s.valid = 1; s.wb_we = 1; s.wb_addr = 7; s.wb_data = 7; s.rs = 7; s.ra = 0;
    step(s);
`ifdef ID_WB_BYPASS_EN
    check_eq("t5_bypass", ex_a, 7);
`else
    check_eq("t5_no_bypass", ex_a, 0);
`endif
    s = idle_stim();
    s.valid = 1; s.wb_we = 1; s.wb_addr = 0; s.wb_data = 32'h55; s.rs = 0;
    s.ra = 32'h77;
    step(s);
    check_eq("t5_r0", ex_a, 0);

    // Random traffic; a stalled instruction is presented again
    s = rand_stim();
    for (int i = 0; i < 400; i++) begin
      step(s);
      if (last_stall) s.flush = ($urandom_range(0, 99) < 10);
      else            s = rand_stim();
    end

    // Reset in the middle of traffic, then behaves as from power-up
    do_reset(2);
    s = idle_stim();
    s.valid = 1; s.pc = 32'h40; s.rs = 5; s.rt = 6; s.ra = 5; s.rb = 6;
    step(s);
    check_eq("post_rst_pc", ex_pc, 32'h40);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(ld);
      step(use_s);
      step(use_s);
    end
    check_eq("sat_cnt", stall_cnt, CNT_MAX);

    // ---------------- final report ----------------
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
